dm_responder: RTL and testbench

Data-memory responder for the pipelined CPU's load/store port. It accepts one load or store request at a time over a valid/ready handshake and models a memory with a fixed, configurable access latency. Stores are applied as byte-lane merges for sw/sh/sb, and loads are returned sign- or zero-extended for lw/lh/lhu/lb/lbu. It sits on the MEM-stage side of the data port, and its `busy` output drives the pipeline stall logic.

---
 rtl/dm_responder.sv | 190 +++++++++++++++++++
 tb/tb_dm_responder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// ============================================================================
// Module   : dm_responder
// Purpose  : Fixed-latency data-memory responder for the CPU load/store port;
//            byte-lane stores, sign/zero-extended loads. Optional alignment
//            faulting is enabled by defining DM_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_wr,
    input  logic [3:0]  req_rd,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;
    logic [1:0]          wr_q, wr_d;
    logic [3:0]          rd_q, rd_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic [31:0]         mem_q [2**ADDR_W];

    logic [ADDR_W-1:0]   w_idx;
    logic [31:0]         w_word;
    logic [31:0]         w_new_word;
    logic [31:0]         w_load_data;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic                w_is_load;
    logic                w_is_store;
    logic                w_misaligned;
    logic                w_err;
    logic                w_mem_we;
    logic                w_unused_addr;

    assign w_unused_addr = ^req_addr[31:ADDR_W+2];

    assign w_idx      = addr_q[ADDR_W+1:2];
    assign w_word     = mem_q[w_idx];
    assign w_byte     = w_word[{addr_q[1:0], 3'b000} +: 8];
    assign w_half     = w_word[{addr_q[1], 4'b0000} +: 16];
    assign w_is_store = (wr_q != 2'b00);
    assign w_is_load  = (rd_q >= 4'd1) && (rd_q <= 4'd5);

`ifdef DM_ALIGN_CHECK_EN
    assign w_misaligned = (((wr_q == 2'b01) || (rd_q == 4'd1)) && (addr_q[1:0] != 2'b00)) ||
                          (((wr_q == 2'b10) || (rd_q == 4'd2) || (rd_q == 4'd3)) && addr_q[0]);
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_err = (w_is_store && w_is_load) || w_misaligned;

    // Read-modify-write merge of the addressed word
    always_comb begin
        w_new_word = w_word;
        case (wr_q)
            2'b01:   w_new_word = wdata_q;
            2'b10:   w_new_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            2'b11:   w_new_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            default: w_new_word = w_word;
        endcase
    end

    always_comb begin
        w_load_data = 32'd0;
        case (rd_q)
            4'd1:    w_load_data = w_word;
            4'd2:    w_load_data = {{16{w_half[15]}}, w_half};
            4'd3:    w_load_data = {16'd0, w_half};
            4'd4:    w_load_data = {{24{w_byte[7]}}, w_byte};
            4'd5:    w_load_data = {24'd0, w_byte};
            default: w_load_data = 32'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        wdata_d     = wdata_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;
        w_mem_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    addr_d      = req_addr[ADDR_W+1:0];
                    wr_d        = req_wr;
                    rd_d        = req_rd;
                    wdata_d     = req_wdata;
                    cnt_d       = 4'(LATENCY - 1);
                    req_ready_d = 1'b0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    // Access happens on the edge that enters RESP
                    w_mem_we    = w_is_store && !w_misaligned;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = w_err;
                    rsp_rdata_d = w_err ? 32'd0 : w_load_data;
                    state_d     = S_RESP;
                end
            end
            S_RESP: begin
                req_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                req_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            wr_q        <= 2'b00;
            rd_q        <= 4'd0;
            wdata_q     <= 32'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage is deliberately not reset; reset forces IDLE so no write can fire
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[w_idx] <= w_new_word;
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = ~req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_responder.sv
// ============================================================================
// Module   : tb_dm_responder
// Purpose  : Directed self-checking bench for dm_responder (LATENCY=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dm_responder;

    localparam int ADDR_W  = 10;
    localparam int LATENCY = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_wr;
    logic [3:0]  req_rd;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    dm_responder #(
        .ADDR_W  (ADDR_W),
        .LATENCY (LATENCY)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wr    (req_wr),
        .req_rd    (req_rd),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request from IDLE; returns response data/error. Edges counted
    // from the accepting edge until rsp_valid is seen must equal LATENCY.
    task automatic do_req(input string tag, input logic [1:0] wr, input logic [3:0] rd,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic err);
        int n;
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_wr    = wr;
        req_rd    = rd;
        req_addr  = addr;
        req_wdata = wd;
        tick();
        req_valid = 1'b0;
        req_wr    = 2'b00;
        req_rd    = 4'd0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            if (busy !== 1'b1) check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            tick();
            n++;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        check({tag, "_lat"}, n, LATENCY);
        tick();
        check({tag, "_pulse"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_rdata0"}, rsp_rdata, 32'd0);
        check({tag, "_err0"}, {31'd0, rsp_err}, 32'd0);
    endtask

    logic [31:0] rd_v;
    logic        err_v;
    int          acc[$];
    int          n_rsp;

    initial begin
        rst       = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'd0;
        req_wr    = 2'b00;
        req_rd    = 4'd0;
        req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err",   {31'd0, rsp_err}, 32'd0);

        do_req("sw10", 2'b01, 4'd0, 32'h10, 32'h8765_43A1, rd_v, err_v);
        check("sw10_err", {31'd0, err_v}, 32'd0);
        check("sw10_data", rd_v, 32'd0);
        do_req("lw10", 2'b00, 4'd1, 32'h10, 32'd0, rd_v, err_v);
        check("lw10_data", rd_v, 32'h8765_43A1);
        check("lw10_err", {31'd0, err_v}, 32'd0);
        do_req("lb10", 2'b00, 4'd4, 32'h10, 32'd0, rd_v, err_v);
        check("lb10_data", rd_v, 32'hFFFF_FFA1);
        do_req("lbu10", 2'b00, 4'd5, 32'h10, 32'd0, rd_v, err_v);
        check("lbu10_data", rd_v, 32'h0000_00A1);
        do_req("lh12", 2'b00, 4'd2, 32'h12, 32'd0, rd_v, err_v);
        check("lh12_data", rd_v, 32'hFFFF_8765);
        do_req("lhu12", 2'b00, 4'd3, 32'h12, 32'd0, rd_v, err_v);
        check("lhu12_data", rd_v, 32'h0000_8765);

        do_req("sb11", 2'b11, 4'd0, 32'h11, 32'hFFFF_FFCC, rd_v, err_v);
        do_req("sh12", 2'b10, 4'd0, 32'h12, 32'hABCD_1234, rd_v, err_v);
        do_req("lw10b", 2'b00, 4'd1, 32'h10, 32'd0, rd_v, err_v);
        check("merge_data", rd_v, 32'h1234_CCA1);
        do_req("lh10", 2'b00, 4'd2, 32'h10, 32'd0, rd_v, err_v);
        check("lh10_data", rd_v, 32'hFFFF_CCA1);
        do_req("lbu13", 2'b00, 4'd5, 32'h13, 32'd0, rd_v, err_v);
        check("lbu13_data", rd_v, 32'h0000_0012);
        // 4 KiB address space wraps back onto word 0x10
        do_req("lwwrap", 2'b00, 4'd1, 32'h1010, 32'd0, rd_v, err_v);
        check("wrap_data", rd_v, 32'h1234_CCA1);

        // Reset in WAIT must drop the store
        do_req("sw20", 2'b01, 4'd0, 32'h20, 32'h1111_2222, rd_v, err_v);
        req_valid = 1'b1;
        req_wr    = 2'b01;
        req_addr  = 32'h20;
        req_wdata = 32'hDEAD_BEEF;
        tick();
        req_valid = 1'b0;
        req_wr    = 2'b00;
        check("abort_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_busy0", {31'd0, busy}, 32'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("abort_novalid", {31'd0, rsp_valid}, 32'd0);
            tick();
        end
        do_req("lw20", 2'b00, 4'd1, 32'h20, 32'd0, rd_v, err_v);
        check("abort_keep", rd_v, 32'h1111_2222);

        do_req("sw22", 2'b01, 4'd0, 32'h22, 32'hA5A5_A5A5, rd_v, err_v);
`ifdef DM_ALIGN_CHECK_EN
        check("sw22_err", {31'd0, err_v}, 32'd1);
        do_req("lw20c", 2'b00, 4'd1, 32'h20, 32'd0, rd_v, err_v);
        check("sw22_mem", rd_v, 32'h1111_2222);
        do_req("lh11", 2'b00, 4'd2, 32'h11, 32'd0, rd_v, err_v);
        check("lh11_err", {31'd0, err_v}, 32'd1);
        check("lh11_data", rd_v, 32'd0);
`else
        check("sw22_err", {31'd0, err_v}, 32'd0);
        do_req("lw20c", 2'b00, 4'd1, 32'h20, 32'd0, rd_v, err_v);
        check("sw22_mem", rd_v, 32'hA5A5_A5A5);
`endif

        // Simultaneous store+load: store happens, result zero, error flagged
        do_req("swlw30", 2'b01, 4'd1, 32'h30, 32'h0000_0055, rd_v, err_v);
        check("conf_err", {31'd0, err_v}, 32'd1);
        check("conf_data", rd_v, 32'd0);
        do_req("lw30", 2'b00, 4'd1, 32'h30, 32'd0, rd_v, err_v);
        check("conf_mem", rd_v, 32'h0000_0055);
        do_req("nop", 2'b00, 4'd0, 32'h30, 32'hFFFF_FFFF, rd_v, err_v);
        check("nop_data", rd_v, 32'd0);
        check("nop_err", {31'd0, err_v}, 32'd0);
        do_req("lw30b", 2'b00, 4'd1, 32'h30, 32'd0, rd_v, err_v);
        check("nop_mem", rd_v, 32'h0000_0055);

        // Back-to-back with req_valid held high
        req_valid = 1'b1;
        req_rd    = 4'd1;
        req_addr  = 32'h10;
        n_rsp     = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (busy !== ~req_ready) check("b2b_busy", {31'd0, busy}, {31'd0, ~req_ready});
            if (req_valid && req_ready) acc.push_back(cyc);
            if (rsp_valid) begin
                n_rsp++;
                check("b2b_data", rsp_rdata, 32'h1234_CCA1);
            end
            tick();
        end
        req_valid = 1'b0;
        req_rd    = 4'd0;
        check("b2b_accepts", acc.size(), 4);
        check("b2b_rsps", n_rsp, 4);
        for (int i = 1; i < acc.size(); i++) begin
            check("b2b_spacing", acc[i] - acc[i-1], LATENCY + 2);
        end
        check("final_ready", {31'd0, req_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
